// File: rtl/io_xbar_dest_stamp.sv
// Transmit-side header stamper for the IO crossbar: rewrites the destination
// field of header flits and passes body flits through one val/rdy stage.
module io_xbar_dest_stamp #(
  parameter int WIDTH      = 64,
  parameter int DEST_LO    = 34,
  parameter int DEST_WIDTH = 30,
  parameter int LEN_LO     = 22,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic                  pkt_done,
  output logic                  busy
);

  typedef enum logic {
    S_HDR,
    S_BODY
  } state_e;

  localparam logic [LEN_WIDTH-1:0] CNT_ONE =
    {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 val_q, val_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hdr_stamped;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 accept;

  assign in_rdy  = !val_q || out_rdy;
  assign accept  = in_val && in_rdy;
  assign hdr_len = in_data[LEN_LO +: LEN_WIDTH];

  always_comb begin
    hdr_stamped = in_data;
    hdr_stamped[DEST_LO +: DEST_WIDTH] = cfg_dest;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    val_d   = val_q;
    done_d  = 1'b0;
    if (accept) begin
      val_d = 1'b1;
      unique case (state_q)
        S_HDR: begin
          data_d = hdr_stamped;
          cnt_d  = hdr_len;
          if (hdr_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_BODY;
          end
        end
        S_BODY: begin
          data_d = in_data;
          // saturate so a corrupted count can never wrap
          cnt_d  = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
          if (cnt_q <= CNT_ONE) begin
            state_d = S_HDR;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (out_rdy) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign out_data = data_q;
  assign out_val  = val_q;
  assign pkt_done = done_q;
  assign busy     = (state_q == S_BODY);

endmodule

// File: tb/tb_io_xbar_dest_stamp.sv
// Self-checking bench for io_xbar_dest_stamp: vector table plus
// scoreboarded packet sequences for stalls, reset and max length.
module tb_io_xbar_dest_stamp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] cfg_dest;
  logic [63:0] in_data;
  logic        in_val;
  logic        in_rdy;
  logic [63:0] out_data;
  logic        out_val;
  logic        out_rdy;
  logic        pkt_done;
  logic        busy;

  io_xbar_dest_stamp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_dest (cfg_dest),
    .in_data  (in_data),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .pkt_done (pkt_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] sb[$];
  int          out_cyc_q[$];
  int          cyc      = 0;
  int          out_cnt  = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic        tb_last  = 1'b0;
  logic        done_exp = 1'b0;

  typedef struct {
    logic [63:0] din;
    logic [29:0] dest;
    logic [63:0] dout;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] stamp(input logic [63:0] d,
                                        input logic [29:0] dst);
    logic [63:0] m;
    m = {30'h3FFF_FFFF, 34'h0};
    return (d & ~m) | ({34'h0, dst} << 34);
  endfunction

  function automatic logic [63:0] mk_hdr(input int len);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return (r & ~(64'hFF << 22)) | (64'(len & 8'hFF) << 22);
  endfunction

  // Driver: call at #1 after a posedge; returns at #1 after the accept edge.
  task automatic send(input logic [63:0] d, input logic [63:0] exp,
                      input logic last);
    bit acc = 0;
    in_data = d;
    in_val  = 1'b1;
    tb_last = last;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        sb.push_back(exp);
        acc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    tb_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    idle(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    done_exp <= rst_n && in_val && in_rdy && tb_last;
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (pkt_done) done_cnt++;
    if (rst_n && (pkt_done || done_exp))
      chk("pkt_done", 64'(pkt_done), 64'(done_exp));
    if (rst_n && out_val && out_rdy) begin
      out_cnt++;
      out_cyc_q.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_out", out_data, 64'd0);
        if (out_data == 64'd0) chk("unexpected_out_flag", 64'd1, 64'd0);
      end else begin
        chk("out_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] h, b1, b2, b3, b4;
    int oc, dc;
    bit stop;

    tbl[0] = '{64'h0000_0000_0000_0000, 30'h1234567,
               64'h048D_159C_0000_0000};
    tbl[1] = '{64'hFFFF_FFFF_C03F_FFFF, 30'h0,
               64'h0000_0003_C03F_FFFF};
    tbl[2] = '{64'h0000_0003_0000_0001, 30'h3FFF_FFFF,
               64'hFFFF_FFFF_0000_0001};
    tbl[3] = '{64'hA5A5_A5A5_8000_0000, 30'h1,
               64'h0000_0005_8000_0000};

    rst_n    = 1'b0;
    cfg_dest = '0;
    in_data  = '0;
    in_val   = 1'b0;
    out_rdy  = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // single-flit headers, 1-cycle latency
    foreach (tbl[i]) begin
      cfg_dest = tbl[i].dest;
      send(tbl[i].din, tbl[i].dout, 1'b1);
      @(negedge clk);
      chk("tbl_val", 64'(out_val), 64'd1);
      chk("tbl_data", out_data, tbl[i].dout);
      @(posedge clk);
      #1;
    end
    drain();

    // len=3 back-to-back
    cfg_dest = 30'h2AAA_5555;
    busy_cnt = 0;
    dc = done_cnt;
    out_cyc_q.delete();
    h = mk_hdr(3);
    send(h, stamp(h, cfg_dest), 1'b0);
    for (int i = 0; i < 3; i++) begin
      b1 = {$urandom, $urandom};
      send(b1, b1, i == 2);
    end
    drain();
    chk("t2_busy_cycles", 64'(busy_cnt), 64'd3);
    chk("t2_done_pulses", 64'(done_cnt - dc), 64'd1);
    chk("t2_out_count", 64'(out_cyc_q.size()), 64'd4);
    if (out_cyc_q.size() == 4)
      chk("t2_consecutive", 64'(out_cyc_q[3] - out_cyc_q[0]), 64'd3);

    // 5-cycle downstream stall mid-body
    oc = out_cnt;
    h  = mk_hdr(4);
    b1 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    b3 = {$urandom, $urandom};
    b4 = {$urandom, $urandom};
    send(h, stamp(h, cfg_dest), 1'b0);
    send(b1, b1, 1'b0);
    fork
      begin
        out_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t3_in_rdy", 64'(in_rdy), 64'd0);
          chk("t3_out_val", 64'(out_val), 64'd1);
          chk("t3_hold", out_data, b1);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
      begin
        send(b2, b2, 1'b0);
        send(b3, b3, 1'b0);
        send(b4, b4, 1'b1);
      end
    join
    drain();
    chk("t3_out_count", 64'(out_cnt - oc), 64'd5);

    // cfg_dest change during body
    cfg_dest = 30'h1;
    h = mk_hdr(2);
    send(h, stamp(h, 30'h1), 1'b0);
    cfg_dest = 30'h2;
    b1 = {$urandom, $urandom};
    send(b1, b1, 1'b0);
    b2 = {$urandom, $urandom};
    send(b2, b2, 1'b1);
    h = mk_hdr(1);
    send(h, stamp(h, 30'h2), 1'b0);
    b3 = {$urandom, $urandom};
    send(b3, b3, 1'b1);
    drain();

    // reset in BODY with cnt=5
    h = mk_hdr(8);
    send(h, stamp(h, cfg_dest), 1'b0);
    for (int i = 0; i < 3; i++) begin
      b1 = {$urandom, $urandom};
      send(b1, b1, 1'b0);
    end
    idle(1);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_out_val", 64'(out_val), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    cfg_dest = 30'h0ABC_DEF0;
    h = mk_hdr(0) | 64'hFFFF_FFFC_0000_0000;
    send(h, stamp(h, cfg_dest), 1'b1);
    drain();

    // len=255 with random backpressure
    oc = out_cnt;
    dc = done_cnt;
    stop = 0;
    fork
      begin
        h = mk_hdr(255);
        send(h, stamp(h, cfg_dest), 1'b0);
        for (int i = 0; i < 255; i++) begin
          b1 = {$urandom, $urandom};
          send(b1, b1, i == 254);
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    drain();
    chk("t6_out_count", 64'(out_cnt - oc), 64'd256);
    chk("t6_done_pulses", 64'(done_cnt - dc), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
